bin2bcd_seg_display: RTL and testbench

Sequential, parametrised binary-to-decimal display driver for the DE-board seven-segment displays. It converts a WIDTH-bit unsigned value to DIGITS BCD digits using iterative double-dabble: one shift per clock, with a start/busy/done handshake. It drives DIGITS active-low seven-segment displays and can optionally blank leading zeros. It generalises the fixed 4-bit, two-digit combinational converter to arbitrary width.

---
 rtl/bin2bcd_seg_display_pkg.sv | 35 +++
 rtl/bin2bcd_seg_display_seg7_digit_dec.sv | 33 +++
 rtl/bin2bcd_seg_display.sv | 133 +++++++++++++
 tb/tb_bin2bcd_seg_display.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_seg_display_pkg.sv
// Shared definitions for the binary-to-BCD seven-segment display driver:
// active-low segment codes, the converter FSM state type and a helper used
// for the elaboration-time range check.
package bin2bcd_seg_display_pkg;

  // Active-low segment patterns, bit order g..a (bit0 = a).
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  // 10**n as a 64-bit value, used to prove the digit count can hold 2**WIDTH-1.
  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seg_display_seg7_digit_dec.sv
// One BCD digit to one active-low seven-segment display, with a blank input
// that forces the display dark. Non-decimal codes also show dark.
module seg7_digit_dec
  import bin2bcd_seg_display_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  // Segment lookup; blanking overrides the digit value.
  always_comb begin
    // NOTE: give every always_comb output a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    seg_o = SEG_BLANK;
    if (!blank_i) begin
      case (digit_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/bin2bcd_seg_display.sv
// Sequential double-dabble converter: WIDTH-bit unsigned binary to DIGITS BCD
// digits, one shift per clock, start/busy/done handshake, registered BCD and
// active-low seven-segment outputs with optional leading-zero blanking.
module bin2bcd_seg_display
  import bin2bcd_seg_display_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 3,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  input  logic                  Start,
  input  logic [WIDTH-1:0]      Bin,
  output logic                  Busy,
  output logic                  Done,
  output logic [4*DIGITS-1:0]   BCD,
  output logic [7*DIGITS-1:0]   HEX
);

  localparam int CW = $clog2(WIDTH + 1);

  if (WIDTH < 1 || WIDTH > 32) begin : g_width_check
    $error("bin2bcd_seg_display: WIDTH must be in 1..32");
  end

  if (pow10(DIGITS) <= ((longint'(1) << WIDTH) - 1)) begin : g_digits_check
    $error("bin2bcd_seg_display: DIGITS too small for 2**WIDTH-1");
  end

  state_e                state_q;
  logic [WIDTH-1:0]      shift_q;
  logic [4*DIGITS-1:0]   scratch_q;
  logic [CW-1:0]         cnt_q;
  logic                  busy_q;
  logic                  done_q;
  logic [4*DIGITS-1:0]   bcd_q;
  logic [7*DIGITS-1:0]   hex_q;

  logic [4*DIGITS-1:0]   corr;
  logic [4*DIGITS-1:0]   scratch_d;
  logic [WIDTH-1:0]      shift_d;
  logic [DIGITS-1:0]     blank;
  logic                  lz_run;
  logic [7*DIGITS-1:0]   hex_d;
  logic                  last_shift;

  // One double-dabble step: add 3 to every digit >= 5, then shift left by one.
  always_comb begin
    corr = scratch_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        corr[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
    {scratch_d, shift_d} = {corr, shift_q} << 1;
  end

  // Leading-zero detection from the top digit down; digit 0 is never blanked.
  always_comb begin
    blank  = '0;
    lz_run = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      lz_run   = lz_run && (scratch_d[4*i +: 4] == 4'd0);
      blank[i] = BLANK_LZ && lz_run;
    end
  end

  // Segment decode of the post-shift scratch, latched into HEX on the last shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    seg7_digit_dec u_dec (
      .digit_i (scratch_d[4*g +: 4]),
      .blank_i (blank[g]),
      .seg_o   (hex_d[7*g +: 7])
    );
  end

  assign last_shift = (cnt_q == CW'(WIDTH - 1));

  // Converter FSM with registered handshake and display outputs.
  always_ff @(posedge Clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!Resetn) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bcd_q     <= '0;
      hex_q     <= '1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (Start) begin
            shift_q   <= Bin;
            scratch_q <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= SHIFT;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          scratch_q <= scratch_d;
          shift_q   <= shift_d;
          cnt_q     <= cnt_q + CW'(1);
          if (last_shift) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            bcd_q   <= scratch_d;
            hex_q   <= hex_d;
            state_q <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign Busy = busy_q;
  assign Done = done_q;
  assign BCD  = bcd_q;
  assign HEX  = hex_q;

endmodule

// File: tb/tb_bin2bcd_seg_display.sv
// Directed bench for bin2bcd_seg_display: default configuration, a copy with
// leading-zero blanking off (sharing the same stimulus) and a 16-bit/5-digit copy.
module tb_bin2bcd_seg_display;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start;
  logic [7:0]  bin;
  logic        busy, done;
  logic [11:0] bcd;
  logic [20:0] hex;

  logic        busy_n, done_n;
  logic [11:0] bcd_n;
  logic [20:0] hex_n;

  logic        start16;
  logic [15:0] bin16;
  logic        busy16, done16;
  logic [19:0] bcd16;
  logic [34:0] hex16;

  int total = 0;
  int bad   = 0;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SB = 7'b1111111;

  bin2bcd_seg_display dut (
    .Clock(clk), .Resetn(rst_n), .Start(start), .Bin(bin),
    .Busy(busy), .Done(done), .BCD(bcd), .HEX(hex)
  );

  bin2bcd_seg_display #(.WIDTH(8), .DIGITS(3), .BLANK_LZ(1'b0)) dut_nlz (
    .Clock(clk), .Resetn(rst_n), .Start(start), .Bin(bin),
    .Busy(busy_n), .Done(done_n), .BCD(bcd_n), .HEX(hex_n)
  );

  bin2bcd_seg_display #(.WIDTH(16), .DIGITS(5), .BLANK_LZ(1'b1)) dut_w16 (
    .Clock(clk), .Resetn(rst_n), .Start(start16), .Bin(bin16),
    .Busy(busy16), .Done(done16), .BCD(bcd16), .HEX(hex16)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until Done (bounded), counting cycles and Busy cycles seen.
  task automatic wait_done(output int n, output int nb);
    n  = 0;
    nb = 0;
    do begin
      if (busy) nb++;
      tick();
      n++;
    end while (!done && n < 40);
    check("done_seen", 64'(done), 64'd1);
  endtask

  task automatic convert(input string tag, input logic [7:0] v,
                         input logic [11:0] exp_bcd, input logic [20:0] exp_hex);
    int n, nb;
    bin   = v;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n, nb);
    check({tag, "_latency"}, 64'(n), 64'd8);
    check({tag, "_busy_cycles"}, 64'(nb), 64'd8);
    check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    check({tag, "_bcd"}, 64'(bcd), 64'(exp_bcd));
    check({tag, "_hex"}, 64'(hex), 64'(exp_hex));
    tick();
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nb, dn;
    logic [11:0] got_bcd;

    rst_n   = 1'b0;
    start   = 1'b0;
    bin     = 8'd0;
    start16 = 1'b0;
    bin16   = 16'd0;
    tick();
    tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_bcd", 64'(bcd), 64'd0);
    check("rst_hex", 64'(hex), 64'h1F_FFFF);
    check("rst_hex16", 64'(hex16), 64'h7_FFFF_FFFF);
    rst_n = 1'b1;
    tick();

    // Zero, full-scale and the 9/10 blanking boundary.
    convert("zero", 8'd0, 12'h000, {SB, SB, S0});
    check("zero_nlz_hex", 64'(hex_n), 64'({S0, S0, S0}));
    convert("max", 8'd255, 12'h255, {S2, S5, S5});
    convert("nine", 8'd9, 12'h009, {SB, SB, S9});
    check("nine_nlz_hex", 64'(hex_n), 64'({S0, S0, S9}));
    convert("ten", 8'd10, 12'h010, {SB, S1, S0});
    check("ten_nlz_hex", 64'(hex_n), 64'({S0, S1, S0}));
    check("ten_nlz_bcd", 64'(bcd_n), 64'h010);

    // Start while busy is ignored.
    bin   = 8'd100;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    bin   = 8'd7;
    start = 1'b1;
    tick();
    start   = 1'b0;
    bin     = 8'd0;
    dn      = 0;
    got_bcd = '0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        dn++;
        got_bcd = bcd;
      end
      tick();
    end
    check("ignore_done_count", 64'(dn), 64'd1);
    check("ignore_bcd", 64'(got_bcd), 64'h100);
    check("ignore_idle_busy", 64'(busy), 64'd0);

    // Reset mid-conversion aborts without Done.
    bin   = 8'd200;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    check("abort_done", 64'(done), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_bcd", 64'(bcd), 64'd0);
    check("abort_hex", 64'(hex), 64'h1F_FFFF);
    rst_n = 1'b1;
    dn    = 0;
    for (int i = 0; i < 15; i++) begin
      if (done || busy) dn++;
      tick();
    end
    check("abort_stays_idle", 64'(dn), 64'd0);

    // Back-to-back conversions with Start held high.
    bin   = 8'd42;
    start = 1'b1;
    tick();
    wait_done(n, nb);
    check("b2b_first_latency", 64'(n), 64'd8);
    check("b2b_bcd_42", 64'(bcd), 64'h042);
    check("b2b_hex_42", 64'(hex), 64'({SB, S4, S2}));
    bin = 8'd137;
    wait_done(n, nb);
    check("b2b_period_137", 64'(n), 64'd9);
    check("b2b_busy_137", 64'(nb), 64'd8);
    check("b2b_bcd_137", 64'(bcd), 64'h137);
    check("b2b_hex_137", 64'(hex), 64'({S1, S3, S7}));
    bin = 8'd0;
    wait_done(n, nb);
    check("b2b_period_0", 64'(n), 64'd9);
    check("b2b_bcd_0", 64'(bcd), 64'h000);
    check("b2b_hex_0", 64'(hex), 64'({SB, SB, S0}));
    start = 1'b0;
    tick();
    check("b2b_stop", 64'(done), 64'd0);

    // Wide configuration at full scale.
    bin16   = 16'd65535;
    start16 = 1'b1;
    tick();
    start16 = 1'b0;
    n  = 0;
    nb = 0;
    do begin
      if (busy16) nb++;
      tick();
      n++;
    end while (!done16 && n < 60);
    check("w16_done_seen", 64'(done16), 64'd1);
    check("w16_latency", 64'(n), 64'd16);
    check("w16_busy_cycles", 64'(nb), 64'd16);
    check("w16_bcd", 64'(bcd16), 64'h65535);
    check("w16_hex", 64'(hex16), 64'({S6, S5, S5, S3, S5}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
